// File: rtl/sha256_param_engine.sv
// SHA-256 engine hashing a run-time-length message held in word memory.
// Supports byte-granular padding, optional double hashing and 1/2/4 rounds per clock.
module sha256_param_engine #(
  parameter int unsigned MAX_BYTES        = 1024,
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        double_hash,
  input  logic [15:0] num_bytes,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        err,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  localparam int unsigned CYCLES   = 64 / ROUNDS_PER_CYCLE;
  localparam logic [6:0]  LAST_RND = 7'(CYCLES - 1);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [2:0] {IDLE, READ, BLOCK, COMPUTE, UPDATE, SECOND, WRITE} state_t;
  state_t state, state_d;

  logic [31:0] hv [8];
  logic [31:0] wv [8];
  logic [31:0] w [16];
  logic [31:0] wv_d [8];
  logic [31:0] w_d [16];
  logic [31:0] blk_buf [16];
  logic [6:0]  cnt;
  logic [10:0] blk, last_blk;
  logic [15:0] nbytes_q, msg_q, out_q;
  logic        dbl_q, second_q, too_big;
  logic [31:0] t1, t2, wn, rd_word;
  logic [5:0]  rnd_idx;
  logic [3:0]  rd_idx;
  logic [16:0] byte_base, blk_base, pad_off;

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign too_big = 32'(num_bytes) > MAX_BYTES;
  assign mem_clk = clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start && !too_big) state_d = READ;
      READ:    if (cnt == 7'd16) state_d = BLOCK;
      BLOCK:   state_d = COMPUTE;
      COMPUTE: if (cnt == LAST_RND) state_d = UPDATE;
      UPDATE: begin
        if (!second_q && blk != last_blk) state_d = READ;
        else if (dbl_q && !second_q)      state_d = SECOND;
        else                              state_d = WRITE;
      end
      SECOND:  state_d = COMPUTE;
      WRITE:   if (cnt == 7'd7) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done           = (state == IDLE);
    mem_we         = (state == WRITE);
    mem_addr       = '0;
    mem_write_data = '0;
    if (state == READ && cnt < 7'd16)
      mem_addr = msg_q + {1'b0, blk, 4'b0000} + {12'b0, cnt[3:0]};
    else if (state == WRITE) begin
      mem_addr       = out_q + {13'b0, cnt[2:0]};
      mem_write_data = hv[cnt[2:0]];
    end
  end

  // Bytes at or beyond the message end are zeroed as each word arrives.
  always_comb begin
    rd_idx    = 4'(cnt - 7'd1);
    byte_base = {blk, rd_idx, 2'b00};
    rd_word   = '0;
    for (int unsigned j = 0; j < 4; j++)
      if (byte_base + 17'(j) < {1'b0, nbytes_q})
        rd_word[31-8*j -: 8] = mem_read_data[31-8*j -: 8];
  end

  always_comb begin
    blk_buf  = w;
    blk_base = {blk, 6'b000000};
    pad_off  = {1'b0, nbytes_q} - blk_base;
    if ({1'b0, nbytes_q} >= blk_base && pad_off < 17'd64)
      blk_buf[pad_off[5:2]] = blk_buf[pad_off[5:2]] | (32'h8000_0000 >> {pad_off[1:0], 3'b000});
    if (blk == last_blk) begin
      blk_buf[14] = '0;
      blk_buf[15] = {13'b0, nbytes_q, 3'b000};
    end
  end

  // w[0] always holds W[t]; the window shifts one word per round.
  always_comb begin
    wv_d    = wv;
    w_d     = w;
    t1      = '0;
    t2      = '0;
    wn      = '0;
    rnd_idx = '0;
    for (int unsigned r = 0; r < ROUNDS_PER_CYCLE; r++) begin
      rnd_idx = 6'(32'(cnt) * ROUNDS_PER_CYCLE + r);
      t1 = wv_d[7] + bsig1(wv_d[4]) + ((wv_d[4] & wv_d[5]) ^ (~wv_d[4] & wv_d[6]))
         + K[rnd_idx] + w_d[0];
      t2 = bsig0(wv_d[0]) + ((wv_d[0] & wv_d[1]) ^ (wv_d[0] & wv_d[2]) ^ (wv_d[1] & wv_d[2]));
      wv_d[7] = wv_d[6];
      wv_d[6] = wv_d[5];
      wv_d[5] = wv_d[4];
      wv_d[4] = wv_d[3] + t1;
      wv_d[3] = wv_d[2];
      wv_d[2] = wv_d[1];
      wv_d[1] = wv_d[0];
      wv_d[0] = t1 + t2;
      wn = ssig1(w_d[14]) + w_d[9] + ssig0(w_d[1]) + w_d[0];
      for (int unsigned i = 0; i < 15; i++) w_d[i] = w_d[i+1];
      w_d[15] = wn;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      blk      <= '0;
      last_blk <= '0;
      nbytes_q <= '0;
      msg_q    <= '0;
      out_q    <= '0;
      dbl_q    <= 1'b0;
      second_q <= 1'b0;
      err      <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        hv[i] <= '0;
        wv[i] <= '0;
      end
      for (int unsigned i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      err <= (state == IDLE) && start && too_big;
      cnt <= (state_d != state) ? '0 : cnt + 7'd1;
      unique case (state)
        IDLE: if (start && !too_big) begin
          nbytes_q <= num_bytes;
          msg_q    <= message_addr;
          out_q    <= output_addr;
          dbl_q    <= double_hash;
          second_q <= 1'b0;
          blk      <= '0;
          last_blk <= 11'((17'(num_bytes) + 17'd8) >> 6);
          hv       <= IV;
        end
        READ:    if (cnt != '0) w[rd_idx] <= rd_word;
        BLOCK: begin
          w  <= blk_buf;
          wv <= hv;
        end
        COMPUTE: begin
          w  <= w_d;
          wv <= wv_d;
        end
        UPDATE: begin
          for (int unsigned i = 0; i < 8; i++) hv[i] <= hv[i] + wv[i];
          if (state_d == READ) blk <= blk + 11'd1;
        end
        SECOND: begin
          for (int unsigned i = 0; i < 8; i++) w[i] <= hv[i];
          w[8] <= 32'h8000_0000;
          for (int unsigned i = 9; i < 15; i++) w[i] <= '0;
          w[15]    <= 32'h0000_0100;
          hv       <= IV;
          wv       <= IV;
          second_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
